// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-high segment patterns, bit order g..a.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // True when digit i is a leading zero (all digits i..3 are zero); digit 0 never blanks.
    function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] i);
        case (i)
            2'd0:    return 1'b0;
            2'd1:    return (d[15:4] == 12'h000);
            2'd2:    return (d[15:8] == 8'h00);
            default: return (d[15:12] == 4'h0);
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern (g..a).
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with guard blanking and frame-aligned updates.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_mask,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic        frame_start,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int MAXV = (TICK_DIV > GUARD_CYC) ? TICK_DIV : GUARD_CYC;
    localparam int CW   = $clog2(MAXV);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYC - 1);

    state_t        state, state_nx;
    logic [1:0]    idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [15:0]   disp_reg, disp_nx;
    logic [3:0]    dp_reg, dp_reg_nx;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          dp_nx, upd_ack_nx, frame_start_nx;
    logic          boundary, load, blank;
    logic [3:0]    nib;
    logic [6:0]    seg_hi;

    assign boundary  = (state == GUARD) && (cnt == '0) && (idx == 2'd0);
    assign load      = boundary && upd_req;
    assign disp_nx   = load ? digits : disp_reg;
    assign dp_reg_nx = load ? dp_in : dp_reg;

    // Decode from the post-load value so a fresh update shows in the ack cycle.
    assign nib = disp_nx[{idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (seg_hi)
    );

`ifdef SEG_LZ_BLANK_EN
    assign blank = lz_blank(disp_nx, idx);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        cnt_nx         = cnt - CW'(1);
        an_nx          = an;
        seg_nx         = seg;
        dp_nx          = dp;
        upd_ack_nx     = 1'b0;
        frame_start_nx = 1'b0;
        case (state)
            GUARD: begin
                if (cnt == '0) begin
                    state_nx       = SHOW;
                    cnt_nx         = SHOW_LOAD;
                    frame_start_nx = (idx == 2'd0);
                    upd_ack_nx     = load;
                    an_nx          = en_mask[idx] ? ~(4'b0001 << idx) : AN_OFF;
                    seg_nx         = blank ? SEG_OFF : ~seg_hi;
                    dp_nx          = ~dp_reg_nx[idx];
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    state_nx = GUARD;
                    cnt_nx   = GUARD_LOAD;
                    idx_nx   = idx + 2'd1;
                    an_nx    = AN_OFF;
                    seg_nx   = SEG_OFF;
                    dp_nx    = 1'b1;
                end
            end
            default: begin
                state_nx = GUARD;
                cnt_nx   = GUARD_LOAD;
            end
        endcase
    end

    // Reset preloads the first guard interval so the first lit slot follows GUARD_CYC off cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= GUARD;
            idx         <= 2'd0;
            cnt         <= GUARD_LOAD;
            disp_reg    <= 16'h0000;
            dp_reg      <= 4'h0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            disp_reg    <= disp_nx;
            dp_reg      <= dp_reg_nx;
            an          <= an_nx;
            seg         <= seg_nx;
            dp          <= dp_nx;
            upd_ack     <= upd_ack_nx;
            frame_start <= frame_start_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=8, GUARD_CYC=2 (40-cycle frame).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  en_mask;
    logic        upd_req;
    logic        upd_ack;
    logic        frame_start;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int vectors = 0;
    int miscompares = 0;
    int t = 0;
    int acks = 0;

`ifdef SEG_LZ_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    seg_scan_ctrl #(.TICK_DIV(8), .GUARD_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_in       (dp_in),
        .en_mask     (en_mask),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, t);
        end
    endtask

    // Advance to just after posedge number e (counted from the last reset release); sample at negedge.
    task automatic to_edge(input int e);
        repeat (e - t) @(negedge clk);
        t = e;
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                            input logic dp_e);
        chk({tag, "_an"}, {12'h0, an}, {12'h0, an_e});
        chk({tag, "_seg"}, {9'h0, seg}, {9'h0, seg_e});
        chk({tag, "_dp"}, {15'h0, dp}, {15'h0, dp_e});
    endtask

    initial begin
        rst = 1'b0; digits = 16'h0000; dp_in = 4'h0; en_mask = 4'hF; upd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_disp("in_reset", 4'hF, 7'h7F, 1'b1);
        chk("in_reset_fs", {15'h0, frame_start}, 16'h0);
        chk("in_reset_ack", {15'h0, upd_ack}, 16'h0);

        rst = 1'b1; t = 0;
        to_edge(1);
        chk_disp("guard1", 4'hF, 7'h7F, 1'b1);
        to_edge(2);
        chk_disp("first_lit", 4'hE, 7'h40, 1'b1);
        chk("first_fs", {15'h0, frame_start}, 16'h1);
        chk("first_ack", {15'h0, upd_ack}, 16'h0);
        to_edge(3);
        chk("fs_pulse", {15'h0, frame_start}, 16'h0);
        to_edge(9);
        chk("slot0_end_an", {12'h0, an}, 16'hE);
        to_edge(10);
        chk_disp("guard_after0", 4'hF, 7'h7F, 1'b1);
        to_edge(12);
        chk_disp("slot1_zero", 4'hD, 7'h40, 1'b1);

        to_edge(15);
        digits = 16'h1234; dp_in = 4'h0; upd_req = 1'b1;
        to_edge(22);
        chk("midframe_ack", {15'h0, upd_ack}, 16'h0);
        chk("slot2_an", {12'h0, an}, 16'hB);
        to_edge(41);
        chk("pre_bound_ack", {15'h0, upd_ack}, 16'h0);
        chk("guard3_an", {12'h0, an}, 16'hF);
        to_edge(42);
        chk("bound_ack", {15'h0, upd_ack}, 16'h1);
        chk("bound_fs", {15'h0, frame_start}, 16'h1);
        chk_disp("d0_4", 4'hE, 7'h19, 1'b1);
        upd_req = 1'b0;
        to_edge(43);
        chk("ack_pulse", {15'h0, upd_ack}, 16'h0);
        chk("d0_hold", {9'h0, seg}, 16'h19);
        to_edge(52);
        chk_disp("d1_3", 4'hD, 7'h30, 1'b1);
        to_edge(62);
        chk_disp("d2_2", 4'hB, 7'h24, 1'b1);
        to_edge(72);
        chk_disp("d3_1", 4'h7, 7'h79, 1'b1);
        to_edge(82);
        chk("frame2_fs", {15'h0, frame_start}, 16'h1);
        chk("frame2_noack", {15'h0, upd_ack}, 16'h0);
        chk_disp("frame2_d0", 4'hE, 7'h19, 1'b1);

        en_mask = 4'b0101;
        to_edge(92);
        chk("mask_slot1", {12'h0, an}, 16'hF);
        to_edge(102);
        chk_disp("mask_slot2", 4'hB, 7'h24, 1'b1);
        to_edge(112);
        chk("mask_slot3", {12'h0, an}, 16'hF);
        to_edge(121);
        chk("mask_pre_fs", {15'h0, frame_start}, 16'h0);
        to_edge(122);
        chk("mask_fs", {15'h0, frame_start}, 16'h1);
        chk("mask_slot0", {12'h0, an}, 16'hE);

        en_mask = 4'hF; digits = 16'h0040; dp_in = 4'b1000; upd_req = 1'b1;
        to_edge(162);
        chk("lz_ack", {15'h0, upd_ack}, 16'h1);
        chk("lz_fs", {15'h0, frame_start}, 16'h1);
        chk_disp("lz_d0", 4'hE, 7'h40, 1'b1);
        to_edge(163);
        chk("lz_ack_pulse", {15'h0, upd_ack}, 16'h0);
        to_edge(172);
        chk_disp("lz_d1", 4'hD, 7'h19, 1'b1);
        to_edge(182);
        chk_disp("lz_d2", 4'hB, LZ_SEG, 1'b1);
        to_edge(192);
        chk_disp("lz_d3", 4'h7, LZ_SEG, 1'b0);
        to_edge(202);
        chk("hold_ack", {15'h0, upd_ack}, 16'h1);
        chk("hold_fs", {15'h0, frame_start}, 16'h1);
        for (int e = 203; e <= 242; e++) begin
            to_edge(e);
            if (upd_ack === 1'b1) acks++;
            chk("ack_with_fs", {15'h0, upd_ack & ~frame_start}, 16'h0);
        end
        chk("acks_per_frame", 16'(acks), 16'd1);
        upd_req = 1'b0;

        to_edge(265);
        rst = 1'b0;
        to_edge(266);
        chk_disp("midslot_rst", 4'hF, 7'h7F, 1'b1);
        chk("midslot_rst_ack", {15'h0, upd_ack}, 16'h0);
        chk("midslot_rst_fs", {15'h0, frame_start}, 16'h0);
        to_edge(268);
        rst = 1'b1; t = 0;
        to_edge(2);
        chk_disp("post_rst_d0", 4'hE, 7'h40, 1'b1);
        chk("post_rst_ack", {15'h0, upd_ack}, 16'h0);
        chk("post_rst_fs", {15'h0, frame_start}, 16'h1);
        to_edge(12);
        chk_disp("post_rst_d1", 4'hD, 7'h40, 1'b1);
        to_edge(32);
        chk_disp("post_rst_d3", 4'h7, 7'h40, 1'b1);
        to_edge(42);
        chk("post_rst_noack", {15'h0, upd_ack}, 16'h0);
        chk("post_rst_fs2", {15'h0, frame_start}, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
